// File: rtl/obi_periph_demux.sv
// OBI one-master to N-peripheral demultiplexer with in-order response tracking,
// an internal error slot for unmapped addresses, and per-target dead detection.
module obi_periph_demux #(
    parameter int                          ADDR_WIDTH      = 32,
    parameter int                          DATA_WIDTH      = 32,
    parameter int                          NUM_TARGETS     = 4,
    parameter logic [NUM_TARGETS*8-1:0]    TARGET_MASK     = {8'h0F, 8'h0E, 8'h0A, 8'h02},
    parameter int                          MAX_OUTSTANDING = 2,
    parameter int                          TIMEOUT_CYCLES  = 255,
    parameter logic [DATA_WIDTH-1:0]       ERR_RDATA       = 32'hDEADBEEF
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic                              m_req_i,
    input  logic                              m_we_i,
    input  logic [ADDR_WIDTH-1:0]             m_addr_i,
    input  logic [DATA_WIDTH/8-1:0]           m_be_i,
    input  logic [DATA_WIDTH-1:0]             m_wdata_i,
    output logic                              m_gnt_o,
    output logic                              m_rvalid_o,
    output logic                              m_err_o,
    output logic [DATA_WIDTH-1:0]             m_rdata_o,
    output logic [NUM_TARGETS-1:0]            t_req_o,
    input  logic [NUM_TARGETS-1:0]            t_gnt_i,
    input  logic [NUM_TARGETS-1:0]            t_rvalid_i,
    output logic [ADDR_WIDTH-1:0]             t_addr_o,
    output logic                              t_we_o,
    output logic [DATA_WIDTH/8-1:0]           t_be_o,
    output logic [DATA_WIDTH-1:0]             t_wdata_o,
    input  logic [NUM_TARGETS*DATA_WIDTH-1:0] t_rdata_i,
    input  logic                              clr_dead_i,
    output logic [NUM_TARGETS-1:0]            dead_o
);

    localparam int IDW = $clog2(NUM_TARGETS + 1);
    localparam int PW  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int OW  = $clog2(MAX_OUTSTANDING + 1);
    localparam int CW  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    localparam logic [IDW-1:0] ERR_ID    = IDW'(NUM_TARGETS);
    localparam logic [PW-1:0]  LAST_PTR  = PW'(MAX_OUTSTANDING - 1);
    localparam logic [OW-1:0]  FULL_CNT  = OW'(MAX_OUTSTANDING);
    localparam logic [CW-1:0]  TMO_LIMIT = CW'(TIMEOUT_CYCLES);

    logic [IDW-1:0]         fifo_q [MAX_OUTSTANDING];
    logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [OW-1:0]          cnt_q, cnt_d;
    logic [IDW-1:0]         last_id_q, last_id_d;
    logic [CW-1:0]          tmo_q, tmo_d;
    logic [NUM_TARGETS-1:0] dead_q, dead_d;

    logic                   fifo_empty, fifo_full;
    logic [IDW-1:0]         dec_id, push_id, head_id;
    logic                   dec_dead, local_err, issue_ok, sel_gnt, push, pop;
    logic                   head_is_tgt, head_dead, head_rvalid, head_live;
    logic [DATA_WIDTH-1:0]  head_rdata;
    logic                   timeout, head_err, tgt_rsp, rsp_err;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    assign fifo_empty = (cnt_q == '0);
    assign fifo_full  = (cnt_q == FULL_CNT);

    // Lowest matching index wins, so scan from the top down.
    always_comb begin
        dec_id   = ERR_ID;
        dec_dead = 1'b0;
        for (int i = NUM_TARGETS - 1; i >= 0; i--) begin
            if (m_addr_i[31:24] == TARGET_MASK[i*8 +: 8]) begin
                dec_id   = IDW'(i);
                dec_dead = dead_q[i];
            end
        end
    end

    assign push_id   = dec_dead ? ERR_ID : dec_id;
    assign local_err = (push_id == ERR_ID);
    assign issue_ok  = !fifo_full && (fifo_empty || (push_id == last_id_q));

    always_comb begin
        sel_gnt = 1'b0;
        for (int i = 0; i < NUM_TARGETS; i++) begin
            if (dec_id == IDW'(i)) begin
                sel_gnt = t_gnt_i[i];
            end
        end
    end

    assign m_gnt_o = issue_ok && (local_err ? m_req_i : sel_gnt);
    assign push    = m_req_i && m_gnt_o;

    for (genvar gi = 0; gi < NUM_TARGETS; gi++) begin : g_treq
        assign t_req_o[gi] = m_req_i && issue_ok && !local_err && (dec_id == IDW'(gi));
    end

    assign t_addr_o  = m_addr_i;
    assign t_we_o    = m_we_i;
    assign t_be_o    = m_be_i;
    assign t_wdata_o = m_wdata_i;

    assign head_id = fifo_q[rd_ptr_q];

    always_comb begin
        head_is_tgt = 1'b0;
        head_dead   = 1'b0;
        head_rvalid = 1'b0;
        head_rdata  = '0;
        for (int i = 0; i < NUM_TARGETS; i++) begin
            if (head_id == IDW'(i)) begin
                head_is_tgt = 1'b1;
                head_dead   = dead_q[i];
                head_rvalid = t_rvalid_i[i];
                head_rdata  = t_rdata_i[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Entries queued for a target that has since died are answered locally.
    assign head_live = !fifo_empty && head_is_tgt && !head_dead;
    assign timeout   = head_live && (tmo_q == TMO_LIMIT);
    assign head_err  = !fifo_empty && !head_live;
    assign tgt_rsp   = head_live && head_rvalid && !timeout;
    assign rsp_err   = head_err || timeout;
    assign pop       = tgt_rsp || rsp_err;

    assign m_rvalid_o = pop;
    assign m_err_o    = rsp_err;
    assign m_rdata_o  = tgt_rsp ? head_rdata : (rsp_err ? ERR_RDATA : '0);
    assign dead_o     = dead_q;

    always_comb begin
        cnt_d = cnt_q;
        if (push && !pop) begin
            cnt_d = cnt_q + 1'b1;
        end else if (!push && pop) begin
            cnt_d = cnt_q - 1'b1;
        end
        wr_ptr_d  = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d  = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        last_id_d = push ? push_id : last_id_q;

        tmo_d = tmo_q;
        if (pop || fifo_empty) begin
            tmo_d = '0;
        end else if (head_live) begin
            tmo_d = tmo_q + 1'b1;
        end

        // A timeout on the head overrides a simultaneous clear for its own bit.
        dead_d = clr_dead_i ? '0 : dead_q;
        for (int i = 0; i < NUM_TARGETS; i++) begin
            if (timeout && (head_id == IDW'(i))) begin
                dead_d[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
            last_id_q <= ERR_ID;
            tmo_q     <= '0;
            dead_q    <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            cnt_q     <= cnt_d;
            last_id_q <= last_id_d;
            tmo_q     <= tmo_d;
            dead_q    <= dead_d;
        end
    end

    // Slot contents are only meaningful under cnt_q, so no reset is needed.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= push_id;
        end
    end

endmodule

// File: tb/tb_obi_periph_demux.sv
// Directed scoreboard bench for obi_periph_demux: stimulus pushes expected
// responses, a monitor pops and compares each m_rvalid_o beat.
module tb_obi_periph_demux;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         m_req, m_we;
    logic [31:0]  m_addr, m_wdata;
    logic [3:0]   m_be;
    logic         m_gnt, m_rvalid, m_err;
    logic [31:0]  m_rdata;
    logic [3:0]   t_req, t_gnt, t_rvalid;
    logic [31:0]  t_addr, t_wdata;
    logic         t_we;
    logic [3:0]   t_be;
    logic [127:0] t_rdata;
    logic         clr_dead;
    logic [3:0]   dead;

    logic [31:0]  tgt_data [4];
    logic [3:0]   rsp_en;

    typedef struct packed {
        logic        err;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   rsp_cnt = 0;
    int   last_rsp_cyc = 0;
    int   last_gnt_cyc = 0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign t_rdata = {tgt_data[3], tgt_data[2], tgt_data[1], tgt_data[0]};

    obi_periph_demux dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .m_req_i    (m_req),
        .m_we_i     (m_we),
        .m_addr_i   (m_addr),
        .m_be_i     (m_be),
        .m_wdata_i  (m_wdata),
        .m_gnt_o    (m_gnt),
        .m_rvalid_o (m_rvalid),
        .m_err_o    (m_err),
        .m_rdata_o  (m_rdata),
        .t_req_o    (t_req),
        .t_gnt_i    (t_gnt),
        .t_rvalid_i (t_rvalid),
        .t_addr_o   (t_addr),
        .t_we_o     (t_we),
        .t_be_o     (t_be),
        .t_wdata_o  (t_wdata),
        .t_rdata_i  (t_rdata),
        .clr_dead_i (clr_dead),
        .dead_o     (dead)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Targets always grant and answer two cycles after acceptance (if enabled).
    initial begin : target_model
        logic [3:0] acc;
        logic [3:0] d1;
        logic [3:0] d2;
        acc = '0;
        d1 = '0;
        d2 = '0;
        t_rvalid = '0;
        forever begin
            @(negedge clk);
            acc = t_req & t_gnt;
            @(posedge clk);
            #1;
            d2 = d1;
            d1 = acc;
            t_rvalid = d2 & rsp_en;
        end
    end

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (m_rvalid) begin
                    rsp_cnt++;
                    last_rsp_cyc = cyc;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_rvalid: got err=%0b rdata=%08h expected no response",
                                 m_err, m_rdata);
                    end else begin
                        e = exp_q.pop_front();
                        chk("rsp_err", {63'b0, m_err}, {63'b0, e.err});
                        chk("rsp_rdata", {32'b0, m_rdata}, {32'b0, e.data});
                        $display("rsp cyc=%0d err=%0b rdata=%08h (exp err=%0b rdata=%08h)",
                                 cyc, m_err, m_rdata, e.err, e.data);
                    end
                end else begin
                    chk("idle_rdata_zero", {32'b0, m_rdata}, 64'h0);
                end
            end
        end
    end

    // Caller is at posedge+1; returns at posedge+1 after the grant edge.
    task automatic issue(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                         input logic [3:0] exp_treq, input logic exp_err, input logic [31:0] exp_data);
        bit done;
        done = 0;
        m_req = 1'b1;
        m_we = we;
        m_addr = addr;
        m_wdata = wdata;
        for (int k = 0; k < 400 && !done; k++) begin
            @(negedge clk);
            if (m_gnt) begin
                chk("grant_treq", {60'b0, t_req}, {60'b0, exp_treq});
                chk("broadcast", {t_addr, t_wdata}, {m_addr, m_wdata});
                chk("broadcast_ctl", {59'b0, t_we, t_be}, {59'b0, m_we, m_be});
                last_gnt_cyc = cyc;
                exp_q.push_back('{err: exp_err, data: exp_data});
                $display("req cyc=%0d addr=%08h we=%0b t_req=%b", cyc, addr, we, t_req);
                done = 1;
            end
            @(posedge clk);
            #1;
        end
        m_req = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL grant_timeout: got no grant for addr %08h expected grant", addr);
        end
    endtask

    task automatic wait_drain(input int budget);
        for (int k = 0; k < budget && exp_q.size() > 0; k++) begin
            @(negedge clk);
        end
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending responses expected 0", exp_q.size());
            exp_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got no completion expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int n0;
        m_req = 1'b0;
        m_we = 1'b0;
        m_addr = '0;
        m_wdata = '0;
        m_be = 4'hF;
        clr_dead = 1'b0;
        t_gnt = 4'hF;
        rsp_en = 4'hF;
        tgt_data[0] = 32'hA0A0_0000;
        tgt_data[1] = 32'h1111_0001;
        tgt_data[2] = 32'h0000_1234;
        tgt_data[3] = 32'h3333_0003;

        repeat (3) @(negedge clk);
        chk("reset_rvalid", {63'b0, m_rvalid}, 64'h0);
        chk("reset_err", {63'b0, m_err}, 64'h0);
        chk("reset_dead", {60'b0, dead}, 64'h0);
        chk("reset_rdata", {32'b0, m_rdata}, 64'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Mapped read, 0x0E selects target 2
        issue(32'h0E00_0010, 1'b0, 32'h0, 4'b0100, 1'b0, 32'h0000_1234);
        wait_drain(20);
        chk("read_latency", 64'(last_rsp_cyc - last_gnt_cyc), 64'd2);

        // Unmapped read answered by the error slot
        issue(32'h5500_0000, 1'b0, 32'h0, 4'b0000, 1'b1, 32'hDEAD_BEEF);
        wait_drain(20);
        chk("err_latency", 64'(last_rsp_cyc - last_gnt_cyc), 64'd1);

        // Write to target 1
        issue(32'h0A00_0040, 1'b1, 32'hCAFE_F00D, 4'b0010, 1'b0, 32'h1111_0001);
        wait_drain(20);

        // Cross-target request blocked while a different target is outstanding
        issue(32'h0A00_0100, 1'b0, 32'h0, 4'b0010, 1'b0, 32'h1111_0001);
        m_req = 1'b1;
        m_addr = 32'h0F00_0000;
        @(negedge clk);
        chk("order_gnt_blocked", {63'b0, m_gnt}, 64'h0);
        chk("order_treq_blocked", {60'b0, t_req}, 64'h0);
        @(posedge clk);
        #1;
        issue(32'h0F00_0000, 1'b0, 32'h0, 4'b1000, 1'b0, 32'h3333_0003);
        wait_drain(20);

        // Two back-to-back to target 3, then target 0 while full
        issue(32'h0F00_0000, 1'b0, 32'h0, 4'b1000, 1'b0, 32'h3333_0003);
        issue(32'h0F00_0004, 1'b0, 32'h0, 4'b1000, 1'b0, 32'h3333_0003);
        m_req = 1'b1;
        m_addr = 32'h0200_0000;
        @(negedge clk);
        chk("full_gnt_blocked", {63'b0, m_gnt}, 64'h0);
        chk("full_treq_blocked", {60'b0, t_req}, 64'h0);
        @(posedge clk);
        #1;
        issue(32'h0200_0000, 1'b0, 32'h0, 4'b0001, 1'b0, 32'hA0A0_0000);
        wait_drain(20);

        // Target 2 stops answering: timeout, dead flag, local error, clear
        rsp_en[2] = 1'b0;
        issue(32'h0E00_0020, 1'b0, 32'h0, 4'b0100, 1'b1, 32'hDEAD_BEEF);
        wait_drain(400);
        chk("timeout_latency", 64'(last_rsp_cyc - last_gnt_cyc), 64'd256);
        chk("dead_set", {60'b0, dead}, 64'h4);
        issue(32'h0E00_0020, 1'b0, 32'h0, 4'b0000, 1'b1, 32'hDEAD_BEEF);
        wait_drain(20);
        chk("dead_err_latency", 64'(last_rsp_cyc - last_gnt_cyc), 64'd1);
        chk("dead_sticky", {60'b0, dead}, 64'h4);
        clr_dead = 1'b1;
        @(posedge clk);
        #1;
        clr_dead = 1'b0;
        chk("dead_clr", {60'b0, dead}, 64'h0);
        rsp_en[2] = 1'b1;
        issue(32'h0E00_0030, 1'b0, 32'h0, 4'b0100, 1'b0, 32'h0000_1234);
        wait_drain(20);
        chk("restored_latency", 64'(last_rsp_cyc - last_gnt_cyc), 64'd2);

        // Reset with two transactions outstanding
        issue(32'h0A00_0000, 1'b0, 32'h0, 4'b0010, 1'b0, 32'h1111_0001);
        issue(32'h0A00_0004, 1'b0, 32'h0, 4'b0010, 1'b0, 32'h1111_0001);
        rst_n = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("midrst_rvalid", {63'b0, m_rvalid}, 64'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        n0 = rsp_cnt;
        repeat (6) @(negedge clk);
        chk("no_stale_rvalid", 64'(rsp_cnt - n0), 64'h0);
        @(posedge clk);
        #1;
        issue(32'h0A00_0008, 1'b0, 32'h0, 4'b0010, 1'b0, 32'h1111_0001);
        wait_drain(20);
        chk("post_rst_latency", 64'(last_rsp_cyc - last_gnt_cyc), 64'd2);

        chk("scoreboard_empty", 64'(exp_q.size()), 64'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
